rv32im_mem_arb: RTL

//  Shares one single-port memory bus between instruction fetch (IFU, read-only) and the EXU load/store

---
 rtl/rv32im_mem_arb_pkg.sv | 20 ++
 rtl/rv32im_mem_arb_wdog.sv | 31 +++
 rtl/rv32im_mem_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32im_mem_arb_pkg.sv
// Shared types and constants for the rv32im memory arbiter.
// The state encoding and watchdog default live here for the top and its watchdog.
package rv32im_mem_arb_pkg;

    localparam int unsigned MEM_ARB_STATE_WIDTH     = 3;
    localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [MEM_ARB_STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_IFU = 3'd1,
        ST_REQ_LSU = 3'd2,
        ST_RSP_IFU = 3'd3,
        ST_RSP_LSU = 3'd4
    } arb_state_e;

    function automatic logic is_lsu_state(arb_state_e s);
        return (s == ST_REQ_LSU) || (s == ST_RSP_LSU);
    endfunction

endpackage

// File: rtl/rv32im_mem_arb_wdog.sv
// Transaction watchdog for rv32im_mem_arb: counts cycles while a transaction is open
// and flags expiry on the TIMEOUT_CYCLES-th cycle. Used only with RV32IM_MEM_ARB_TIMEOUT_EN.
module rv32im_mem_arb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count value 0 is the first open cycle, so LAST marks the TIMEOUT_CYCLES-th one.
    assign expired_o = enable && (cnt_q == LAST);

endmodule

// File: rtl/rv32im_mem_arb.sv
// Single-port memory arbiter between IFU fetches and LSU loads/stores, one transaction at a time.
// Optional watchdog enabled by defining RV32IM_MEM_ARB_TIMEOUT_EN.
module rv32im_mem_arb
    import rv32im_mem_arb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ifu_req_i,
    input  logic [AW-1:0] ifu_addr_i,
    output logic          ifu_gnt_o,
    output logic          ifu_rvalid_o,
    output logic [DW-1:0] ifu_rdata_o,
    output logic          ifu_err_o,
    input  logic          lsu_req_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [DW-1:0] lsu_wdata_i,
    input  logic [3:0]    lsu_wmask_i,
    output logic          lsu_gnt_o,
    output logic          lsu_rvalid_o,
    output logic [DW-1:0] lsu_rdata_o,
    output logic          lsu_err_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_wmask_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i
);

    arb_state_e    state_q, state_d;
    logic          last_lsu_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wmask_q;
    logic [DW-1:0] ifu_rdata_q, lsu_rdata_q;
    logic          in_req, in_rsp, for_lsu;
    logic          grant_ifu, grant_lsu;
    logic          resp, tmo, tmo_hit, done;
    logic [DW-1:0] rsp_data;

    assign in_req  = (state_q == ST_REQ_IFU) || (state_q == ST_REQ_LSU);
    assign in_rsp  = (state_q == ST_RSP_IFU) || (state_q == ST_RSP_LSU);
    assign for_lsu = is_lsu_state(state_q);

    // LSU has priority unless it won the previous arbitration round.
    assign grant_lsu = rst_ni && (state_q == ST_IDLE) && lsu_req_i && (!ifu_req_i || !last_lsu_q);
    assign grant_ifu = rst_ni && (state_q == ST_IDLE) && ifu_req_i && !grant_lsu;

    assign resp     = (in_req && mem_gnt_i && mem_rvalid_i) || (in_rsp && mem_rvalid_i);
    assign tmo_hit  = tmo && !resp;
    assign done     = resp || tmo_hit;
    assign rsp_data = tmo_hit ? '0 : mem_rdata_i;

`ifdef RV32IM_MEM_ARB_TIMEOUT_EN
    logic wdog_clear, wdog_en;
    assign wdog_clear = grant_ifu || grant_lsu;
    assign wdog_en    = in_req || in_rsp;

    rv32im_mem_arb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    (wdog_clear),
        .enable   (wdog_en),
        .expired_o(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_lsu)      state_d = ST_REQ_LSU;
                else if (grant_ifu) state_d = ST_REQ_IFU;
            end
            ST_REQ_IFU, ST_REQ_LSU: begin
                if (done)           state_d = ST_IDLE;
                else if (mem_gnt_i) state_d = for_lsu ? ST_RSP_LSU : ST_RSP_IFU;
            end
            ST_RSP_IFU, ST_RSP_LSU: begin
                if (done)           state_d = ST_IDLE;
            end
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_lsu_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (grant_lsu) begin
                last_lsu_q <= 1'b1;
                addr_q     <= lsu_addr_i;
                wdata_q    <= lsu_wdata_i;
                wmask_q    <= lsu_wmask_i;
            end else if (grant_ifu) begin
                last_lsu_q <= 1'b0;
                addr_q     <= ifu_addr_i;
                wdata_q    <= '0;
                wmask_q    <= '0;
            end
            if (done && !for_lsu) ifu_rdata_q <= rsp_data;
            if (done && for_lsu)  lsu_rdata_q <= rsp_data;
        end
    end

    assign ifu_gnt_o    = grant_ifu;
    assign lsu_gnt_o    = grant_lsu;
    assign ifu_rvalid_o = done && !for_lsu;
    assign lsu_rvalid_o = done && for_lsu;
    assign ifu_err_o    = tmo_hit && !for_lsu;
    assign lsu_err_o    = tmo_hit && for_lsu;
    // Response data is forwarded in the rvalid cycle and held afterwards.
    assign ifu_rdata_o  = ifu_rvalid_o ? rsp_data : ifu_rdata_q;
    assign lsu_rdata_o  = lsu_rvalid_o ? rsp_data : lsu_rdata_q;
    assign mem_req_o    = in_req && !tmo_hit;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wmask_o  = wmask_q;

endmodule
